// File: rtl/adc_write_manager.sv
// Per-input event RAM write controller: writes one half-package of ADC samples per accepted
// trigger into the circular RAM, queues triggers that arrive while busy or while the RAM is full.
module adc_write_manager #(
  parameter int unsigned PENDING_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        live_rising,
  input  logic        trigger,
  input  logic [15:0] adc_data,
  input  logic [9:0]  HALF_PACKAGE_LENGTH,
  input  logic [13:0] MEMORY_DEPTH,
  input  logic [4:0]  MAX_NEVENT,
  input  logic [15:0] n_read,
  output logic        wen,
  output logic [13:0] waddr,
  output logic [15:0] wdata,
  output logic        w_complete,
  output logic [15:0] n_written,
  output logic [3:0]  pending,
  output logic        busy,
  output logic        trig_lost
);

  typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

  localparam logic [3:0] PendMax = 4'(PENDING_MAX);

  state_e      state_q, state_d;
  logic        wen_q, wen_d;
  logic [13:0] waddr_q, waddr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        w_complete_q, w_complete_d;
  logic [15:0] n_written_q, n_written_d;
  logic [3:0]  pending_q, pending_d;
  logic        busy_q, busy_d;
  logic        trig_lost_q, trig_lost_d;
  logic [13:0] base_q, base_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [9:0]  hpl_q, hpl_d;

  logic        space;
  logic        start;
  logic [14:0] base_sum;
  logic [13:0] base_next;
  logic [13:0] waddr_inc;

  always_comb begin
    space     = (n_written_q - n_read) < {11'd0, MAX_NEVENT};
    start     = (state_q != StWrite) && space && ((pending_q != 4'd0) || trigger);
    base_sum  = {1'b0, base_q} + {5'd0, hpl_q};
    base_next = (MEMORY_DEPTH == 14'd0) ? 14'd0 : 14'(base_sum % {1'b0, MEMORY_DEPTH});
    waddr_inc = (waddr_q == MEMORY_DEPTH - 14'd1) ? 14'd0 : waddr_q + 14'd1;

    state_d      = state_q;
    wen_d        = wen_q;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    w_complete_d = 1'b0;
    n_written_d  = n_written_q;
    pending_d    = pending_q;
    trig_lost_d  = trig_lost_q;
    base_d       = base_q;
    cnt_d        = cnt_q;
    hpl_d        = hpl_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          hpl_d   = HALF_PACKAGE_LENGTH;
          waddr_d = base_q;
          wdata_d = adc_data;
          cnt_d   = 10'd1;
          if (HALF_PACKAGE_LENGTH == 10'd0) begin
            // Empty package: complete immediately without touching the RAM.
            wen_d        = 1'b0;
            state_d      = StDone;
            w_complete_d = 1'b1;
            n_written_d  = n_written_q + 16'd1;
          end else begin
            wen_d   = 1'b1;
            state_d = StWrite;
          end
        end else begin
          wen_d   = 1'b0;
          state_d = StIdle;
        end
      end
      StWrite: begin
        if (cnt_q < hpl_q) begin
          waddr_d = waddr_inc;
          wdata_d = adc_data;
          cnt_d   = cnt_q + 10'd1;
        end else begin
          wen_d        = 1'b0;
          state_d      = StDone;
          w_complete_d = 1'b1;
          n_written_d  = n_written_q + 16'd1;
          base_d       = base_next;
        end
      end
      default: state_d = StIdle;
    endcase

    // A trigger arriving with a dequeue nets out; a trigger consumed directly leaves the queue.
    if (start) begin
      if ((pending_q != 4'd0) && !trigger) begin
        pending_d = pending_q - 4'd1;
      end
    end else if (trigger) begin
      if (pending_q == PendMax) begin
        trig_lost_d = 1'b1;
      end else begin
        pending_d = pending_q + 4'd1;
      end
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || live_rising) begin
      state_q      <= StIdle;
      wen_q        <= 1'b0;
      waddr_q      <= 14'd0;
      wdata_q      <= 16'd0;
      w_complete_q <= 1'b0;
      n_written_q  <= 16'd0;
      pending_q    <= 4'd0;
      busy_q       <= 1'b0;
      trig_lost_q  <= 1'b0;
      base_q       <= 14'd0;
      cnt_q        <= 10'd0;
      hpl_q        <= 10'd0;
    end else begin
      state_q      <= state_d;
      wen_q        <= wen_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      w_complete_q <= w_complete_d;
      n_written_q  <= n_written_d;
      pending_q    <= pending_d;
      busy_q       <= busy_d;
      trig_lost_q  <= trig_lost_d;
      base_q       <= base_d;
      cnt_q        <= cnt_d;
      hpl_q        <= hpl_d;
    end
  end

  assign wen        = wen_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign w_complete = w_complete_q;
  assign n_written  = n_written_q;
  assign pending    = pending_q;
  assign busy       = busy_q;
  assign trig_lost  = trig_lost_q;

endmodule

// File: tb/tb_adc_write_manager.sv
// Scoreboard bench for adc_write_manager: expected RAM writes and completions are queued when
// each trigger is issued and popped by a monitor whenever the DUT presents wen or w_complete.
module tb_adc_write_manager;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        live_rising;
  logic        trigger;
  logic [15:0] adc_data;
  logic [9:0]  hpl;
  logic [13:0] depth;
  logic [4:0]  max_nev;
  logic [15:0] n_read;
  logic        wen;
  logic [13:0] waddr;
  logic [15:0] wdata;
  logic        w_complete;
  logic [15:0] n_written;
  logic [3:0]  pending;
  logic        busy;
  logic        trig_lost;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  assign adc_data = 16'(cyc) ^ 16'hA5A5;

  adc_write_manager dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .live_rising         (live_rising),
    .trigger             (trigger),
    .adc_data            (adc_data),
    .HALF_PACKAGE_LENGTH (hpl),
    .MEMORY_DEPTH        (depth),
    .MAX_NEVENT          (max_nev),
    .n_read              (n_read),
    .wen                 (wen),
    .waddr               (waddr),
    .wdata               (wdata),
    .w_complete          (w_complete),
    .n_written           (n_written),
    .pending             (pending),
    .busy                (busy),
    .trig_lost           (trig_lost)
  );

  typedef struct {
    int          c;
    logic [13:0] a;
    logic [15:0] d;
  } wr_t;

  typedef struct {
    int          c;
    logic [15:0] nw;
  } cp_t;

  wr_t wq[$];
  cp_t cq[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  function automatic logic [15:0] pat(int k);
    return 16'(k) ^ 16'hA5A5;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected writes for one event whose first wen cycle is 'first'.
  task automatic push_event(int first, int base, int n, int dep, int nw, bit complete);
    wr_t e;
    cp_t p;
    int  a = base;
    for (int i = 0; i < n; i++) begin
      e.c = first + i;
      e.a = 14'(a);
      e.d = pat(first - 1 + i);
      wq.push_back(e);
      a = (a == dep - 1) ? 0 : a + 1;
    end
    if (complete) begin
      p.c  = first + n;
      p.nw = 16'(nw);
      cq.push_back(p);
    end
  endtask

  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_trig();
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_wen"}, 32'(wen), 32'd0);
    check({tag, "_waddr"}, 32'(waddr), 32'd0);
    check({tag, "_wdata"}, 32'(wdata), 32'd0);
    check({tag, "_w_complete"}, 32'(w_complete), 32'd0);
    check({tag, "_n_written"}, 32'(n_written), 32'd0);
    check({tag, "_pending"}, 32'(pending), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_trig_lost"}, 32'(trig_lost), 32'd0);
  endtask

  task automatic clear_run(string tag);
    check({tag, "_sb_drained"}, 32'(wq.size() + cq.size()), 32'd0);
    wq.delete();
    cq.delete();
    live_rising = 1'b1;
    @(negedge clk);
    live_rising = 1'b0;
    @(negedge clk);
  endtask

  always @(negedge clk) begin : monitor
    wr_t e;
    cp_t p;
    if (wen === 1'b1) begin
      n_tests++;
      if (wq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: waddr %0h wdata %0h at cycle %0d, none expected",
                 waddr, wdata, cyc);
      end else begin
        e = wq.pop_front();
        if (e.c != cyc || e.a !== waddr || e.d !== wdata) begin
          n_fail++;
          $display("FAIL write: got cyc %0d addr %0h data %0h expected cyc %0d addr %0h data %0h",
                   cyc, waddr, wdata, e.c, e.a, e.d);
        end
      end
    end
    if (w_complete === 1'b1) begin
      n_tests++;
      if (cq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_complete: n_written %0h at cycle %0d, none expected",
                 n_written, cyc);
      end else begin
        p = cq.pop_front();
        if (p.c != cyc || p.nw !== n_written) begin
          n_fail++;
          $display("FAIL complete: got cyc %0d n_written %0h expected cyc %0d n_written %0h",
                   cyc, n_written, p.c, p.nw);
        end
      end
    end
  end

  initial begin
    int t;
    int u;
    int bases[4];
    rst_n       = 1'b0;
    live_rising = 1'b0;
    trigger     = 1'b0;
    hpl         = 10'd4;
    depth       = 14'd16;
    max_nev     = 5'd4;
    n_read      = 16'd0;
    cycles(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    cycles(5);

    // Single event, then a second one from the advanced base address.
    t = cyc;
    push_event(t + 1, 0, 4, 16, 1, 1'b1);
    pulse_trig();
    cycles(8);
    check("single_n_written", 32'(n_written), 32'd1);
    check("single_busy_idle", 32'(busy), 32'd0);
    t = cyc;
    push_event(t + 1, 4, 4, 16, 2, 1'b1);
    pulse_trig();
    cycles(8);
    clear_run("single");

    // Address wrap-around in a 12-word RAM.
    hpl   = 10'd5;
    depth = 14'd12;
    bases = '{0, 5, 10, 3};
    for (int k = 0; k < 4; k++) begin
      t = cyc;
      push_event(t + 1, bases[k], 5, 12, k + 1, 1'b1);
      pulse_trig();
      cycles(19);
    end
    check("wrap_n_written", 32'(n_written), 32'd4);
    clear_run("wrap");

    // Queued triggers at t, t+2, t+3.
    hpl   = 10'd8;
    depth = 14'd64;
    t = cyc;
    push_event(t + 1, 0, 8, 64, 1, 1'b1);
    push_event(t + 10, 8, 8, 64, 2, 1'b1);
    push_event(t + 19, 16, 8, 64, 3, 1'b1);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    @(negedge clk);
    trigger = 1'b1;
    cycles(2);
    trigger = 1'b0;
    check("queue_pending_peak", 32'(pending), 32'd2);
    cycles(30);
    check("queue_pending_end", 32'(pending), 32'd0);
    check("queue_trig_lost", 32'(trig_lost), 32'd0);
    check("queue_n_written", 32'(n_written), 32'd3);
    clear_run("queue");

    // Full stall with MAX_NEVENT=2, released by n_read.
    hpl     = 10'd3;
    depth   = 14'd32;
    max_nev = 5'd2;
    t = cyc;
    push_event(t + 1, 0, 3, 32, 1, 1'b1);
    push_event(t + 5, 3, 3, 32, 2, 1'b1);
    trigger = 1'b1;
    cycles(4);
    trigger = 1'b0;
    cycles(16);
    check("stall_pending", 32'(pending), 32'd2);
    check("stall_n_written", 32'(n_written), 32'd2);
    check("stall_busy", 32'(busy), 32'd0);
    u = cyc;
    push_event(u + 1, 6, 3, 32, 3, 1'b1);
    n_read = 16'd1;
    cycles(10);
    check("stall_pending_after", 32'(pending), 32'd1);
    check("stall_n_written_after", 32'(n_written), 32'd3);
    n_read = 16'd0;
    clear_run("stall");

    // Queue saturation with MAX_NEVENT=1.
    hpl     = 10'd4;
    depth   = 14'd16;
    max_nev = 5'd1;
    t = cyc;
    push_event(t + 1, 0, 4, 16, 1, 1'b1);
    trigger = 1'b1;
    cycles(17);
    trigger = 1'b0;
    cycles(10);
    check("sat_pending", 32'(pending), 32'd15);
    check("sat_trig_lost", 32'(trig_lost), 32'd1);
    check("sat_n_written", 32'(n_written), 32'd1);
    clear_run("sat");

    // Reset during the third write cycle, then fresh events including hpl=0.
    max_nev = 5'd4;
    hpl     = 10'd8;
    t = cyc;
    push_event(t + 1, 0, 3, 16, 0, 1'b0);
    pulse_trig();
    cycles(2);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    rst_n = 1'b1;
    cycles(3);
    t = cyc;
    push_event(t + 1, 0, 8, 16, 1, 1'b1);
    pulse_trig();
    cycles(12);
    hpl = 10'd0;
    t = cyc;
    push_event(t + 1, 8, 0, 16, 2, 1'b1);
    pulse_trig();
    cycles(4);
    hpl = 10'd4;
    t = cyc;
    push_event(t + 1, 8, 4, 16, 3, 1'b1);
    pulse_trig();
    cycles(8);
    check("final_n_written", 32'(n_written), 32'd3);
    check("final_sb_drained", 32'(wq.size() + cq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_write_manager.md
# adc_write_manager

Per-input write controller for the event RAM. On each accepted trigger it writes one half-package of ADC samples into the circular even/odd RAM and reports completion to the read manager. It keeps the write pointer in step with the read manager's `init_addr` arithmetic. It also blocks new writes while the RAM already holds `MAX_NEVENT` unread events. Sixteen instances, one per input, sit between the ADC deserialisers and the RAM write ports. Their `w_complete` outputs form the read manager's 16-bit `w_complete` bus.

## Interface
- `PENDING_MAX`, 15: saturation value of the queued-trigger counter (fits `pending` width).
- `clk`  in  1  system clock
- `rst_n`  in  1  synchronous, active-low reset
- `live_rising`  in  1  run-start pulse; same clearing effect as reset
- `trigger`  in  1  accepted-trigger pulse, one cycle per event
- `adc_data`  in  16  sample stream, one sample per clock, already latency-aligned upstream
- `HALF_PACKAGE_LENGTH`  in  10  words per event per input
- `MEMORY_DEPTH`  in  14  RAM depth in words
- `MAX_NEVENT`  in  5  maximum unread events held in RAM
- `n_read`  in  16  events fully read, from the read manager
- `wen`  out  1  RAM write enable
- `waddr`  out  14  RAM write address
- `wdata`  out  16  RAM write data
- `w_complete`  out  1  one-cycle pulse per completed event
- `n_written`  out  16  completed events since reset, wraps modulo 2^16
- `pending`  out  4  triggers queued but not yet started
- `busy`  out  1  high in WRITE or DONE
- `trig_lost`  out  1  sticky; a trigger was dropped because the queue was saturated

## Operation
- **States:** IDLE, WRITE, DONE.
- **Reset:** `rst_n`=0 or `live_rising`=1 takes priority over everything. It forces IDLE and clears `wen`, `waddr`, `wdata`, `w_complete`, `n_written`, `pending`, `busy`, `trig_lost`, `base_addr`, and the word counter. A trigger in that cycle is ignored.
- **space:** `space` = ((`n_written` − `n_read`) mod 2^16) < `MAX_NEVENT`.
- **start:** `start` = (IDLE or DONE) and `space` and (`pending` > 0 or `trigger`).
- **IDLE → WRITE on `start`.**
  - Latch HALF_PACKAGE_LENGTH as `hpl`.
  - Set `waddr` = `base_addr`, `wen` = 1, `wdata` = `adc_data`, word counter = 1.
- **WRITE, per cycle:**
  - If counter < `hpl`: `waddr` = (`waddr` == MEMORY_DEPTH−1) ? 0 : `waddr`+1; `wdata` = `adc_data`; counter+1.
  - Otherwise: `wen` = 0, go to DONE, pulse `w_complete`, increment `n_written`, and set `base_addr` = (`base_addr` + `hpl`) mod MEMORY_DEPTH.
- **DONE** lasts exactly one cycle. If `start` holds, go directly to WRITE; otherwise go to IDLE.
- **hpl = 0:** no `wen` cycles. The block enters DONE on the cycle after start, and `w_complete` and `n_written` behave as normal.
- **Trigger queue, `pending`:**
  - Trigger consumed by `start` with `pending` = 0: `pending` unchanged.
  - `start` dequeues from `pending` > 0 and a trigger arrives in the same cycle: `pending` unchanged.
  - `start` dequeues with no trigger: `pending` − 1.
  - Trigger not consumed: `pending` + 1.
  - Trigger arrives with `pending` = `PENDING_MAX` and is not consumed: trigger dropped, `trig_lost` = 1.
- **Queued events** capture consecutive samples, i.e. the stream from their actual start cycle (piled-event semantics).
- **Buffer full:** with no `space`, the block waits in IDLE. Triggers keep queueing and no data is written.
- **Mid-operation reset:** `wen` drops at the next edge. No `w_complete` is issued for the partial event.

## Timing
- All outputs are registered.
- Trigger at cycle t, IDLE, `space`, `pending` = 0:
  - `wen` high on cycles t+1 … t+hpl.
  - `waddr` = `base_addr` at t+1, then increments each cycle.
  - `wdata` at cycle k = `adc_data` at cycle k−1.
- Completion: `w_complete` high only at t+hpl+1. `n_written` is updated and visible at t+hpl+1.
- Back-to-back queued event: next `wen` at t+hpl+2, provided `space` holds.
- A change in `n_read` is seen by `space` on the next edge.
- `n_written` wraps 0xFFFF → 0x0000. All comparisons use modular difference.

## Test plan
- **Single event:** HPL=4, DEPTH=16, MAX_NEVENT=4, one trigger at t=10 → `wen` at 11–14, `waddr` 0,1,2,3, `w_complete` at 15, `n_written`=1, next `base_addr`=4.
- **Wrap-around:** HPL=5, DEPTH=12, three triggers spaced 20 cycles apart → third event `waddr` 10,11,0,1,2, final `base_addr`=3.
- **Queueing:** HPL=8, triggers at t, t+2, t+3 → `pending` peaks at 2. Events start at t+1, t+10, t+19, with three `w_complete` pulses and `trig_lost`=0.
- **Full stall:** MAX_NEVENT=2, `n_read` held 0, four triggers → two events written, `pending`=2, `wen` stays low. Raising `n_read` to 1 → third event starts within 2 cycles.
- **Saturation:** `n_read` held 0, MAX_NEVENT=1, 17 triggers → `pending`=15, `trig_lost`=1, `n_written`=1.
- **Reset mid-write:** `rst_n` low at the 3rd `wen` cycle → `wen`=0 next cycle, no `w_complete`, all outputs 0. The next trigger writes from `waddr` 0.
